counter_sched: RTL and testbench



---
 rtl/counter_sched_pkg.sv | 16 +
 rtl/counter_sched_if.sv | 44 ++++
 rtl/counter_sched_rr_arbiter.sv | 31 +++
 rtl/counter_sched.sv | 127 ++++++++++++
 tb/tb_counter_sched.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched scheduler slice.
// The optional abort feature is controlled by the COUNTER_SCHED_ABORT_EN macro.
package counter_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_WIDTH   = 8;

endpackage

// File: rtl/counter_sched_if.sv
// Client-facing bundle of the shared-counter scheduler.
// abort_in exists only when COUNTER_SCHED_ABORT_EN is defined.
interface counter_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8
);

  // Handshake: a requester holds req_in high (level) until it sees its gnt_out
  // bit; gnt_out stays high for the whole run and drops together with a
  // one-cycle done_out pulse (or silently on abort). Requests are never latched.
  logic [NUM_REQ-1:0]       req_in;
  logic [NUM_REQ*WIDTH-1:0] load_val_in;
  logic [NUM_REQ-1:0]       dir_in;
`ifdef COUNTER_SCHED_ABORT_EN
  logic                     abort_in;
`endif
  logic [NUM_REQ-1:0]       gnt_out;
  logic [NUM_REQ-1:0]       done_out;
  logic                     busy_out;
  logic [WIDTH-1:0]         count_out;

`ifdef COUNTER_SCHED_ABORT_EN
  modport master (
    output req_in, load_val_in, dir_in, abort_in,
    input  gnt_out, done_out, busy_out, count_out
  );

  modport slave (
    input  req_in, load_val_in, dir_in, abort_in,
    output gnt_out, done_out, busy_out, count_out
  );
`else
  modport master (
    output req_in, load_val_in, dir_in,
    input  gnt_out, done_out, busy_out, count_out
  );

  modport slave (
    input  req_in, load_val_in, dir_in,
    output gnt_out, done_out, busy_out, count_out
  );
`endif

endinterface

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shared up/down counter scheduler: round-robin grant, load, run to terminal, done pulse.
// Define COUNTER_SCHED_ABORT_EN to enable abort_in cancellation of a run.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic            clk_in,
  input  logic            rst_in,
  counter_sched_if.slave  bus,
  output state_t          dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               dir_q, dir_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               at_terminal;
  logic               abort_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (bus.req_in),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_req = bus.abort_in;
`else
  assign abort_req = 1'b0;
`endif

  // The counter saturates at its terminal value; it never wraps.
  assign at_terminal = (dir_q == DIR_UP) ? (count_q == '1) : (count_q == '0);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      dir_q   <= DIR_DOWN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (arb_valid) begin
          state_d = RUN;
          gnt_d   = arb_gnt;
          busy_d  = 1'b1;
          count_d = bus.load_val_in[int'(arb_idx)*WIDTH +: WIDTH];
          dir_d   = bus.dir_in[arb_idx];
          ptr_d   = (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (at_terminal) begin
          state_d = IDLE;
          done_d  = gnt_q;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (dir_q == DIR_UP) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.gnt_out   = gnt_q;
  assign bus.done_out  = done_q;
  assign bus.busy_out  = busy_q;
  assign bus.count_out = count_q;
  assign dbg_state     = state_q;

  a_gnt_onehot: assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(gnt_q));
  a_done_onehot: assert property (@(posedge clk_in) disable iff (rst_in) $onehot0(done_q));
  a_busy_state: assert property (@(posedge clk_in) disable iff (rst_in) busy_q == (state_q == RUN));
  a_gnt_busy: assert property (@(posedge clk_in) disable iff (rst_in) (gnt_q != '0) == busy_q);

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: cycle-by-cycle vector table plus hand-written
// reset-mid-run and (with COUNTER_SCHED_ABORT_EN) abort sequences.
module tb_counter_sched;
  import counter_sched_pkg::*;

  localparam int NR = 2;
  localparam int W  = 8;
  localparam int EW = 2*NR + 1 + W;

  logic   clk_in;
  logic   rst_in;
  state_t dbg_state;

  counter_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  counter_sched #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [NR-1:0] req;
    logic [W-1:0]  l0;
    logic [W-1:0]  l1;
    logic [NR-1:0] dir;
    logic [NR-1:0] gnt;
    logic [NR-1:0] done;
    logic          busy;
    logic [W-1:0]  count;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int tag, input logic [NR-1:0] gnt,
                            input logic [NR-1:0] done, input logic busy, input logic [W-1:0] count);
    check({name, ".gnt"},   tag, 32'(bus.gnt_out),   32'(gnt));
    check({name, ".done"},  tag, 32'(bus.done_out),  32'(done));
    check({name, ".busy"},  tag, 32'(bus.busy_out),  32'(busy));
    check({name, ".count"}, tag, 32'(bus.count_out), 32'(count));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic [W-1:0] l0,
                       input logic [W-1:0] l1, input logic [NR-1:0] dir);
    bus.req_in      = req;
    bus.load_val_in = {l1, l0};
    bus.dir_in      = dir;
  endtask

  task automatic add(input logic [NR-1:0] req, input logic [W-1:0] l0, input logic [W-1:0] l1,
                     input logic [NR-1:0] dir, input logic [NR-1:0] gnt, input logic [NR-1:0] done,
                     input logic busy, input logic [W-1:0] count);
    vec_t v;
    v.req = req; v.l0 = l0; v.l1 = l1; v.dir = dir;
    v.gnt = gnt; v.done = done; v.busy = busy; v.count = count;
    vecs.push_back(v);
  endtask

  initial begin
    logic [EW-1:0] e;

    rst_in = 1'b1;
    drive('0, '0, '0, '0);
`ifdef COUNTER_SCHED_ABORT_EN
    bus.abort_in = 1'b0;
`endif
    step();
    step();
    check_outs("reset", 0, 2'b00, 2'b00, 1'b0, 8'h00);
    check("reset.state", 0, 32'(dbg_state), 32'(IDLE));
    rst_in = 1'b0;
    step();
    check_outs("post_reset_idle", 0, 2'b00, 2'b00, 1'b0, 8'h00);

    //   req    l0     l1     dir    gnt    done   busy  count
    // single down run from 3; owner drops req and load changes are ignored
    add(2'b01, 8'h03, 8'h00, 2'b00, 2'b01, 2'b00, 1'b1, 8'h03);
    add(2'b00, 8'h09, 8'h00, 2'b00, 2'b01, 2'b00, 1'b1, 8'h02);
    add(2'b00, 8'h09, 8'h00, 2'b00, 2'b01, 2'b00, 1'b1, 8'h01);
    add(2'b00, 8'h09, 8'h00, 2'b00, 2'b01, 2'b00, 1'b1, 8'h00);
    add(2'b00, 8'h09, 8'h00, 2'b00, 2'b00, 2'b01, 1'b0, 8'h00);
    add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00);
    // up run from FD to terminal; direction change after grant ignored
    add(2'b10, 8'h00, 8'hFD, 2'b10, 2'b10, 2'b00, 1'b1, 8'hFD);
    add(2'b00, 8'h00, 8'hFD, 2'b00, 2'b10, 2'b00, 1'b1, 8'hFE);
    add(2'b00, 8'h00, 8'hFD, 2'b00, 2'b10, 2'b00, 1'b1, 8'hFF);
    add(2'b00, 8'h00, 8'hFD, 2'b00, 2'b00, 2'b10, 1'b0, 8'hFF);
    add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 8'hFF);
    // round robin with both requesting, L=1 each, no dead cycle between runs
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b01, 2'b00, 1'b1, 8'h01);
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b01, 2'b00, 1'b1, 8'h00);
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b00, 2'b01, 1'b0, 8'h00);
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b10, 2'b00, 1'b1, 8'h01);
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b10, 2'b00, 1'b1, 8'h00);
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b00, 2'b10, 1'b0, 8'h00);
    add(2'b11, 8'h01, 8'h01, 2'b00, 2'b01, 2'b00, 1'b1, 8'h01);
    add(2'b00, 8'h01, 8'h01, 2'b00, 2'b01, 2'b00, 1'b1, 8'h00);
    add(2'b00, 8'h01, 8'h01, 2'b00, 2'b00, 2'b01, 1'b0, 8'h00);
    add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00);
    // terminal load down (pointer sits at 1, req0 wins by wrapping)
    add(2'b01, 8'h00, 8'h00, 2'b00, 2'b01, 2'b00, 1'b1, 8'h00);
    add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b01, 1'b0, 8'h00);
    add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00);
    // terminal load up, owner keeps requesting and is re-granted after done
    add(2'b10, 8'h00, 8'hFF, 2'b10, 2'b10, 2'b00, 1'b1, 8'hFF);
    add(2'b10, 8'h00, 8'hFF, 2'b10, 2'b00, 2'b10, 1'b0, 8'hFF);
    add(2'b10, 8'h00, 8'hFF, 2'b10, 2'b10, 2'b00, 1'b1, 8'hFF);
    add(2'b00, 8'h00, 8'hFF, 2'b10, 2'b00, 2'b10, 1'b0, 8'hFF);
    add(2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 8'hFF);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].l0, vecs[i].l1, vecs[i].dir);
      exp_q.push_back({vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].count});
      step();
      e = exp_q.pop_front();
      check_outs("vec", i, e[EW-1 -: NR], e[W+NR -: NR], e[W], e[W-1:0]);
    end

    // reset in the middle of a down run from 5
    drive(2'b01, 8'h05, 8'h00, 2'b00);
    step();
    check_outs("rst_mid.grant", 0, 2'b01, 2'b00, 1'b1, 8'h05);
    drive(2'b00, 8'h05, 8'h00, 2'b00);
    step();
    step();
    check_outs("rst_mid.run", 2, 2'b01, 2'b00, 1'b1, 8'h03);
    rst_in = 1'b1;
    step();
    check_outs("rst_mid.reset", 3, 2'b00, 2'b00, 1'b0, 8'h00);
    check("rst_mid.state", 3, 32'(dbg_state), 32'(IDLE));
    rst_in = 1'b0;
    step();
    check_outs("rst_mid.after", 4, 2'b00, 2'b00, 1'b0, 8'h00);

`ifdef COUNTER_SCHED_ABORT_EN
    // abort at count 7 of a down run from 10
    drive(2'b10, 8'h00, 8'h0A, 2'b00);
    step();
    check_outs("abort.grant", 0, 2'b10, 2'b00, 1'b1, 8'h0A);
    drive(2'b00, 8'h00, 8'h0A, 2'b00);
    for (int k = 1; k <= 3; k++) step();
    check_outs("abort.at7", 3, 2'b10, 2'b00, 1'b1, 8'h07);
    bus.abort_in = 1'b1;
    step();
    check_outs("abort.cut", 4, 2'b00, 2'b00, 1'b0, 8'h07);
    check("abort.state", 4, 32'(dbg_state), 32'(IDLE));
    // abort held in IDLE does not block a grant
    drive(2'b01, 8'h02, 8'h00, 2'b00);
    step();
    check_outs("abort.idle_ignored", 5, 2'b01, 2'b00, 1'b1, 8'h02);
    bus.abort_in = 1'b0;
    drive(2'b00, 8'h02, 8'h00, 2'b00);
    step();
    step();
    check_outs("abort.at0", 7, 2'b01, 2'b00, 1'b1, 8'h00);
    bus.abort_in = 1'b1;
    step();
    check_outs("abort.terminal", 8, 2'b00, 2'b00, 1'b0, 8'h00);
    bus.abort_in = 1'b0;
    step();
    check_outs("abort.no_done", 9, 2'b00, 2'b00, 1'b0, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
